// File: rtl/move_input_ctrl.sv
// Move input controller: validates Row/Col placement requests against the board
// occupancy and the cat position. It keeps the 8x8 blocked bitmap, offers each
// accepted move over a valid/ready handshake, and holds an error flag for a fixed
// time after each rejected request.
module move_input_ctrl #(
  parameter int unsigned ERR_HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [7:0]  Row,
  input  logic [7:0]  Col,
  input  logic        center_button,
  input  logic        down_button,
  input  logic [2:0]  cat_row,
  input  logic [2:0]  cat_col,
  input  logic        game_over,
  output logic        mv_valid,
  output logic [2:0]  mv_row,
  output logic [2:0]  mv_col,
  input  logic        mv_ready,
  output logic [63:0] blocked,
  output logic [6:0]  move_count,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCheck, StOffer, StError} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(ERR_HOLD_CYCLES - 1);

  localparam logic [1:0] CodeNone     = 2'b00;
  localparam logic [1:0] CodeBadSw    = 2'b01;
  localparam logic [1:0] CodeOccupied = 2'b10;
  localparam logic [1:0] CodeCat      = 2'b11;

  state_e           state_q, state_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       col_q, col_d;
  logic [63:0]      blocked_q, blocked_d;
  logic [6:0]       move_count_q, move_count_d;
  logic             mv_valid_q, mv_valid_d;
  logic [2:0]       mv_row_q, mv_row_d;
  logic [2:0]       mv_col_q, mv_col_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Exactly one bit set; zero or several bits are both rejected.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Index of the set bit of a one-hot byte (LSB is index 0).
  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] e;
    e = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) e = 3'(k);
    end
    return e;
  endfunction

  logic [2:0] req_row, req_col;
  logic [5:0] req_idx;

  assign req_row = enc8(row_q);
  assign req_col = enc8(col_q);
  assign req_idx = {req_row, req_col};  // row*8 + col

  // Next-state logic: clear has priority over everything, then the FSM.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    blocked_d    = blocked_q;
    move_count_d = move_count_q;
    mv_valid_d   = mv_valid_q;
    mv_row_d     = mv_row_q;
    mv_col_d     = mv_col_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    cnt_d        = cnt_q;

    if (down_button) begin
      // A handshake in this cycle is dropped: the move is not delivered.
      state_d      = StIdle;
      blocked_d    = '0;
      move_count_d = '0;
      mv_valid_d   = 1'b0;
      err_d        = 1'b0;
      err_code_d   = CodeNone;
      cnt_d        = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (center_button && !game_over) begin
            row_d   = Row;
            col_d   = Col;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (!is_onehot(row_q) || !is_onehot(col_q)) begin
            err_d      = 1'b1;
            err_code_d = CodeBadSw;
            cnt_d      = '0;
            state_d    = StError;
          end else if (blocked_q[req_idx]) begin
            err_d      = 1'b1;
            err_code_d = CodeOccupied;
            cnt_d      = '0;
            state_d    = StError;
          end else if ((req_row == cat_row) && (req_col == cat_col)) begin
            err_d      = 1'b1;
            err_code_d = CodeCat;
            cnt_d      = '0;
            state_d    = StError;
          end else begin
            blocked_d[req_idx] = 1'b1;
            move_count_d       = move_count_q + 7'd1;
            mv_row_d           = req_row;
            mv_col_d           = req_col;
            mv_valid_d         = 1'b1;
            state_d            = StOffer;
          end
        end
        StOffer: begin
          // game_over does not withdraw an offer already made.
          if (mv_ready) begin
            mv_valid_d = 1'b0;
            state_d    = StIdle;
          end
        end
        StError: begin
          if (cnt_q == CntLast) begin
            err_d      = 1'b0;
            err_code_d = CodeNone;
            cnt_d      = '0;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      blocked_q    <= '0;
      move_count_q <= '0;
      mv_valid_q   <= 1'b0;
      mv_row_q     <= '0;
      mv_col_q     <= '0;
      err_q        <= 1'b0;
      err_code_q   <= CodeNone;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      blocked_q    <= blocked_d;
      move_count_q <= move_count_d;
      mv_valid_q   <= mv_valid_d;
      mv_row_q     <= mv_row_d;
      mv_col_q     <= mv_col_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mv_valid   = mv_valid_q;
  assign mv_row     = mv_row_q;
  assign mv_col     = mv_col_q;
  assign blocked    = blocked_q;
  assign move_count = move_count_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
- Sits directly upstream of the game-logic core.
- Takes the one-hot Row/Col switch banks and the debounced single-cycle button pulses.
- Validates each placement request against the board occupancy and the cat position, then maintains the 8x8 blocked-cell bitmap.
- Offers each accepted move to the game logic over a valid/ready handshake, and flags rejected requests for display.

Parameters:
- ERR_HOLD_CYCLES, default 50000000: cycles that err stays asserted after a rejected request (0.5 s at 100 MHz).
- CNT_W, default 26: width of the error-hold counter. It must hold ERR_HOLD_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- Reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- Row  in  8  row select switches, expected one-hot.
- Col  in  8  column select switches, expected one-hot.
- center_button  in  1  debounced single-cycle pulse: place a block.
- down_button  in  1  debounced single-cycle pulse: clear the board for a new game.
- cat_row  in  3  current cat row.
- cat_col  in  3  current cat column.
- game_over  in  1  level from game logic; blocks new placements.
- mv_valid  out  1  move offer valid.
- mv_row  out  3  encoded row of the offered move.
- mv_col  out  3  encoded column of the offered move.
- mv_ready  in  1  game logic accepts the move.
- blocked  out  64  occupancy bitmap; bit index = row*8+col.
- move_count  out  7  number of accepted placements.
- err  out  1  rejection indicator.
- err_code  out  2  01 = bad switch pattern, 10 = cell occupied, 11 = cat cell.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, Reset_n low): state IDLE; all outputs are 0, including blocked, move_count, mv_row, mv_col and err_code. The error-hold counter is 0.
- Row/Col sampling: latched into internal registers on the center_button pulse in IDLE. Later switch changes have no effect on the request in flight.
- IDLE:
  - center_button=1 and game_over=0 -> latch Row/Col, go to CHECK.
  - center_button while game_over=1 is ignored.
  - center_button in any state other than IDLE is ignored.
- CHECK (exactly one cycle). Checks are applied in this priority order:
  - latched Row or Col not exactly one bit set (zero or multiple) -> ERROR, err_code=01.
  - blocked[r*8+c]=1 -> ERROR, err_code=10.
  - r==cat_row and c==cat_col -> ERROR, err_code=11.
  - otherwise -> set blocked[r*8+c], increment move_count, load mv_row=r and mv_col=c, assert mv_valid, go to OFFER.
- Latency: pulse in cycle N -> CHECK in N+1 -> mv_valid/err, blocked and move_count visible at N+2. All outputs are registered.
- OFFER:
  - mv_valid, mv_row and mv_col are held stable until the cycle where mv_valid and mv_ready are both high.
  - On the following edge, mv_valid drops and the state returns to IDLE. mv_row/mv_col keep their last value.
  - game_over rising during OFFER does not withdraw the offer.
- ERROR:
  - err=1 on entry; the hold counter counts from 0 to ERR_HOLD_CYCLES-1.
  - On terminal count: err=0, err_code=00, return to IDLE.
  - blocked and move_count are unchanged.
- down_button (any state, highest priority):
  - Next edge: blocked=0, move_count=0, mv_valid=0, err=0, err_code=00, counter=0, state IDLE.
  - A simultaneous mv_ready handshake is discarded; the move is not delivered.
  - A simultaneous center_button is ignored.
- move_count: maximum reachable value is 63, because the cat cell can never be blocked. No saturation logic is needed; 7 bits never overflow.
- Switch bit mapping: Row bit k -> row index k; Col bit k -> column index k (LSB = index 0).
- busy = (state != IDLE).

Test Plan:
- Valid placement with backpressure:
  - Stimulus: Row=8'h04, Col=8'h10, cat at (3,3), center pulse, mv_ready held 0 for 5 cycles, then 1.
  - Response: mv_valid=1 at N+2 with mv_row=2, mv_col=4; blocked[20]=1; move_count=1.
  - Offer stays stable through the stall; mv_valid=0 one cycle after the handshake.
- Occupied cell: repeat the same placement -> err=1, err_code=10 for exactly ERR_HOLD_CYCLES (bench uses 16); blocked and move_count unchanged; mv_valid never asserted.
- Bad switch pattern: Row=8'h06, Col=8'h01 -> err_code=01. Row=8'h00 -> err_code=01. Both take priority over the occupancy check.
- Cat cell: cat at (3,3), Row=8'h08, Col=8'h08 -> err_code=11; blocked[27] stays 0.
- Clear during offer: down_button in the same cycle as mv_ready=1 during OFFER -> next cycle mv_valid=0, blocked=64'h0, move_count=0, state IDLE. game_over=1 with a center pulse -> busy stays 0.
- Asynchronous reset: Reset_n low mid-ERROR and between clock edges -> err, err_code, busy and blocked are 0 immediately. After release, a valid press produces mv_valid at N+2.
